// File: rtl/nport_mem_pkg.sv
// rtl/nport_mem_pkg.sv - shared types, defaults and write-grant function for nport_sync_mem
package nport_mem_pkg;

    localparam int DEF_WIDTH  = 8;
    localparam int DEF_ADDR_W = 4;
    localparam int DEF_NPORTS = 3;

    // Widest configuration the grant function handles; callers zero-extend into it.
    localparam int MAX_PORTS  = 8;
    localparam int MAX_ADDR_W = 16;

    typedef enum logic {
        INIT  = 1'b0,
        READY = 1'b1
    } state_t;

    // A port is granted when it writes and no lower-indexed writer shares its address.
    function automatic logic [MAX_PORTS-1:0] write_grant(
        input logic [MAX_PORTS-1:0]            we,
        input logic [MAX_PORTS*MAX_ADDR_W-1:0] addr
    );
        logic [MAX_PORTS-1:0] grant;
        for (int p = 0; p < MAX_PORTS; p++) begin
            grant[p] = we[p];
            for (int q = 0; q < p; q++) begin
                if (we[q] && (addr[q*MAX_ADDR_W +: MAX_ADDR_W] == addr[p*MAX_ADDR_W +: MAX_ADDR_W])) begin
                    grant[p] = 1'b0;
                end
            end
        end
        return grant;
    endfunction

endpackage

// File: rtl/nport_sync_mem_if.sv
// rtl/nport_sync_mem_if.sv - port bundle for nport_sync_mem
interface nport_sync_mem_if
    import nport_mem_pkg::*;
#(
    parameter int WIDTH  = DEF_WIDTH,
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int NPORTS = DEF_NPORTS
) ();

    logic [NPORTS-1:0]        we;
    logic [NPORTS-1:0]        re;
    logic [NPORTS*ADDR_W-1:0] addr;
    logic [NPORTS*WIDTH-1:0]  wr_data;
    logic [NPORTS*WIDTH-1:0]  rd_data;
    logic [NPORTS-1:0]        rd_valid;
    logic [NPORTS-1:0]        wr_drop;
    logic                     init_busy;

    modport master (
        output we, re, addr, wr_data,
        input  rd_data, rd_valid, wr_drop, init_busy
    );

    modport slave (
        input  we, re, addr, wr_data,
        output rd_data, rd_valid, wr_drop, init_busy
    );

endinterface

// File: rtl/nport_wr_arb.sv
// rtl/nport_wr_arb.sv - per-cycle write priority resolution (lowest port index wins)
module nport_wr_arb
    import nport_mem_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int NPORTS = DEF_NPORTS
) (
    input  logic [NPORTS-1:0]        we,
    input  logic [NPORTS*ADDR_W-1:0] addr,
    output logic [NPORTS-1:0]        grant,
    output logic [NPORTS-1:0]        drop
);

    logic [MAX_PORTS-1:0]            we_x;
    logic [MAX_PORTS*MAX_ADDR_W-1:0] addr_x;

    // Widen the request onto the package function's fixed shape, then narrow the result.
    always_comb begin
        we_x   = '0;
        addr_x = '0;
        for (int p = 0; p < NPORTS; p++) begin
            we_x[p] = we[p];
            addr_x[p*MAX_ADDR_W +: MAX_ADDR_W] = MAX_ADDR_W'(addr[p*ADDR_W +: ADDR_W]);
        end
        grant = NPORTS'(write_grant(we_x, addr_x));
        drop  = we & ~grant;
    end

endmodule

// File: rtl/nport_sync_mem.sv
// rtl/nport_sync_mem.sv - N-port synchronous RAM with clear sequencer; NPORT_MEM_BYPASS_EN selects write-through reads
module nport_sync_mem
    import nport_mem_pkg::*;
#(
    parameter int WIDTH  = DEF_WIDTH,
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int NPORTS = DEF_NPORTS
) (
    input  logic             clk,
    input  logic             rst,
    nport_sync_mem_if.slave  bus
);

    localparam int DEPTH = 1 << ADDR_W;

    state_t                  state_q, state_d;
    logic [ADDR_W-1:0]       cnt_q, cnt_d;
    logic                    ready;
    logic [NPORTS-1:0]       grant;
    logic [NPORTS-1:0]       drop;
    logic [NPORTS-1:0]       drop_q;
    logic [NPORTS-1:0]       rd_valid_q;
    logic [NPORTS*WIDTH-1:0] rd_data_q;
    logic [WIDTH-1:0]        rd_next [NPORTS];
    logic [WIDTH-1:0]        mem [DEPTH];

    assign ready = (state_q == READY);

    nport_wr_arb #(
        .ADDR_W (ADDR_W),
        .NPORTS (NPORTS)
    ) u_arb (
        .we    (bus.we),
        .addr  (bus.addr),
        .grant (grant),
        .drop  (drop)
    );

    // State and clear-counter registers; reset always restarts the clear at address 0.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= INIT;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Clear walks every address once, then the memory opens to the ports for good.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (state_q == INIT) begin
            cnt_d = cnt_q + ADDR_W'(1);
            if (cnt_q == ADDR_W'(DEPTH - 1)) begin
                state_d = READY;
            end
        end
    end

    // Array writes: zero fill during clear, granted port writes once ready.
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (!ready) begin
                mem[cnt_q] <= '0;
            end else begin
                for (int p = 0; p < NPORTS; p++) begin
                    if (grant[p]) begin
                        mem[bus.addr[p*ADDR_W +: ADDR_W]] <= bus.wr_data[p*WIDTH +: WIDTH];
                    end
                end
            end
        end
    end

    // Per-port read source: stored word, optionally overridden by a same-edge winning write.
    always_comb begin
        for (int p = 0; p < NPORTS; p++) begin
            rd_next[p] = mem[bus.addr[p*ADDR_W +: ADDR_W]];
`ifdef NPORT_MEM_BYPASS_EN
            for (int q = 0; q < NPORTS; q++) begin
                if (grant[q] && (bus.addr[q*ADDR_W +: ADDR_W] == bus.addr[p*ADDR_W +: ADDR_W])) begin
                    rd_next[p] = bus.wr_data[q*WIDTH +: WIDTH];
                end
            end
`endif
        end
    end

    // Registered read data and valid pulses; data holds when a port is not reading.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_data_q  <= '0;
            rd_valid_q <= '0;
        end else begin
            rd_valid_q <= ready ? bus.re : '0;
            for (int p = 0; p < NPORTS; p++) begin
                if (ready && bus.re[p]) begin
                    rd_data_q[p*WIDTH +: WIDTH] <= rd_next[p];
                end
            end
        end
    end

    // Collision losers are flagged for exactly one cycle after the write edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            drop_q <= '0;
        end else begin
            drop_q <= ready ? drop : '0;
        end
    end

    assign bus.rd_data   = rd_data_q;
    assign bus.rd_valid  = rd_valid_q;
    assign bus.wr_drop   = drop_q;
    assign bus.init_busy = ~ready;

endmodule

// File: tb/tb_nport_sync_mem.sv
// tb/tb_nport_sync_mem.sv - randomized and directed bench for nport_sync_mem against a behavioural model
module tb_nport_sync_mem;
    import nport_mem_pkg::*;

    localparam int W     = 8;
    localparam int AW    = 4;
    localparam int NP    = 3;
    localparam int DEPTH = 1 << AW;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    nport_sync_mem_if #(.WIDTH(W), .ADDR_W(AW), .NPORTS(NP)) bus ();

    nport_sync_mem #(.WIDTH(W), .ADDR_W(AW), .NPORTS(NP)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int vectors     = 0;
    int miscompares = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: memory contents, cycles of clear remaining, expected registered outputs.
    logic [W-1:0]  m_mem [DEPTH];
    logic [W-1:0]  after [DEPTH];
    int            busy_left = 0;
    bit            model_ok  = 0;
    logic [NP-1:0] e_valid;
    logic [NP-1:0] e_drop;
    logic [W-1:0]  e_rd [NP];

    always @(posedge clk) begin
        if (rst) begin
            model_ok  = 1;
            busy_left = DEPTH;
            e_valid   = '0;
            e_drop    = '0;
            for (int p = 0; p < NP; p++) e_rd[p] = '0;
            for (int i = 0; i < DEPTH; i++) m_mem[i] = '0;
        end else if (busy_left > 0) begin
            busy_left--;
            e_valid = '0;
            e_drop  = '0;
        end else begin
            after = m_mem;
            for (int p = NP - 1; p >= 0; p--) begin
                if (bus.we[p]) after[bus.addr[p*AW +: AW]] = bus.wr_data[p*W +: W];
            end
            e_drop = '0;
            for (int p = 0; p < NP; p++) begin
                for (int q = 0; q < p; q++) begin
                    if (bus.we[p] && bus.we[q] && bus.addr[p*AW +: AW] == bus.addr[q*AW +: AW])
                        e_drop[p] = 1'b1;
                end
            end
            e_valid = bus.re;
            for (int p = 0; p < NP; p++) begin
                if (bus.re[p]) begin
`ifdef NPORT_MEM_BYPASS_EN
                    e_rd[p] = after[bus.addr[p*AW +: AW]];
`else
                    e_rd[p] = m_mem[bus.addr[p*AW +: AW]];
`endif
                end
            end
            m_mem = after;
        end
    end

    // Every cycle after the first reset, all outputs must match the model.
    always @(negedge clk) begin
        if (model_ok) begin
            check("init_busy", bus.init_busy, busy_left > 0);
            check("rd_valid", bus.rd_valid, e_valid);
            check("wr_drop", bus.wr_drop, e_drop);
            for (int p = 0; p < NP; p++)
                check($sformatf("rd_data[%0d]", p), bus.rd_data[p*W +: W], e_rd[p]);
        end
    end

    task automatic apply(input logic r, input logic [NP-1:0] w, input logic [NP-1:0] rd,
                         input logic [NP*AW-1:0] a, input logic [NP*W-1:0] d);
        @(negedge clk);
        rst         = r;
        bus.we      = w;
        bus.re      = rd;
        bus.addr    = a;
        bus.wr_data = d;
    endtask

    task automatic idle();
        apply(1'b0, '0, '0, '0, '0);
    endtask

    logic [7:0] rdw_exp;
    logic [AW-1:0] ra [NP];

    initial begin
        rst         = 1'b1;
        bus.we      = '0;
        bus.re      = '0;
        bus.addr    = '0;
        bus.wr_data = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;

        // Clear sequence length and reset values
        check("reset_rd_data", bus.rd_data, 0);
        check("reset_rd_valid", bus.rd_valid, 0);
        check("reset_wr_drop", bus.wr_drop, 0);
        for (int i = 0; i < DEPTH; i++) begin
            check("clear_busy_high", bus.init_busy, 1);
            @(negedge clk);
        end
        check("clear_busy_low", bus.init_busy, 0);

        // Every address reads back zero after clear
        for (int a = 0; a < DEPTH; a++) begin
            apply(1'b0, '0, 3'b111, {4'((a + 10) % DEPTH), 4'((a + 5) % DEPTH), 4'(a)}, '0);
            idle();
            check("clear_rd", bus.rd_data, 0);
            check("clear_rd_valid", bus.rd_valid, 3'b111);
        end

        // Parallel writes to distinct addresses
        apply(1'b0, 3'b111, 3'b000, {4'd9, 4'd7, 4'd3}, {8'h3C, 8'h5A, 8'hA5});
        apply(1'b0, 3'b000, 3'b111, {4'd9, 4'd7, 4'd3}, '0);
        check("par_drop", bus.wr_drop, 3'b000);
        idle();
        check("par_rd", bus.rd_data, 24'h3C5AA5);

        // Three-way collision at address 5
        apply(1'b0, 3'b111, 3'b000, {4'd5, 4'd5, 4'd5}, {8'h33, 8'h22, 8'h11});
        apply(1'b0, 3'b000, 3'b001, {4'd0, 4'd0, 4'd5}, '0);
        check("col_drop", bus.wr_drop, 3'b110);
        idle();
        check("col_drop_pulse", bus.wr_drop, 3'b000);
        check("col_rd", bus.rd_data[7:0], 8'h11);

        // Read during write from another port
        apply(1'b0, 3'b001, 3'b000, {4'd0, 4'd0, 4'd4}, {8'h00, 8'h00, 8'h10});
        apply(1'b0, 3'b010, 3'b001, {4'd0, 4'd4, 4'd4}, {8'h00, 8'h99, 8'h00});
        idle();
`ifdef NPORT_MEM_BYPASS_EN
        rdw_exp = 8'h99;
`else
        rdw_exp = 8'h10;
`endif
        check("rdw_rd", bus.rd_data[7:0], rdw_exp);

        // Reset in READY with a read pending
        apply(1'b0, 3'b001, 3'b000, {4'd0, 4'd0, 4'd2}, {8'h00, 8'h00, 8'hFF});
        apply(1'b1, 3'b000, 3'b001, {4'd0, 4'd0, 4'd2}, '0);
        idle();
        check("midrst_valid", bus.rd_valid, 3'b000);
        check("midrst_busy", bus.init_busy, 1);
        repeat (DEPTH) idle();
        check("midrst_ready", bus.init_busy, 0);
        apply(1'b0, 3'b000, 3'b001, {4'd0, 4'd0, 4'd2}, '0);
        idle();
        check("midrst_rd", bus.rd_data[7:0], 8'h00);
        check("midrst_rd_valid", bus.rd_valid, 3'b001);

        // Requests during clear are ignored
        apply(1'b1, '0, '0, '0, '0);
        apply(1'b0, 3'b001, 3'b000, {4'd1, 4'd1, 4'd1}, {8'h00, 8'h00, 8'h77});
        repeat (DEPTH) idle();
        check("init_req_ready", bus.init_busy, 0);
        apply(1'b0, 3'b000, 3'b001, {4'd0, 4'd0, 4'd1}, '0);
        check("init_req_drop", bus.wr_drop, 3'b000);
        idle();
        check("init_req_rd", bus.rd_data[7:0], 8'h00);

        // Randomized traffic, narrow address range to force collisions, rare resets
        for (int n = 0; n < 500; n++) begin
            for (int p = 0; p < NP; p++)
                ra[p] = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, DEPTH - 1)) : 4'($urandom_range(0, 3));
            apply(($urandom_range(0, 119) == 0), NP'($urandom), NP'($urandom),
                  {ra[2], ra[1], ra[0]}, 24'($urandom));
        end
        repeat (3) idle();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
